if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of buffered fetch entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the PC width.
REQ-003 SHALL have parameter INST_W, default 32, meaning the instruction width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port flush_i  input  1  discards all buffered and presented instructions (branch mispredict).
REQ-007 SHALL have port if_valid_i  input  1  the fetch stage presents an instruction this cycle.
REQ-008 SHALL have port if_pc_i  input  ADDR_W  PC of the presented instruction.
REQ-009 SHALL have port if_inst_i  input  INST_W  the presented instruction word.
REQ-010 SHALL have port if_jump_i  input  1  predicted-taken flag of the presented instruction.
REQ-011 SHALL have port if_ready_o  output  1  the queue accepts an instruction this cycle.
REQ-012 SHALL have port id_stall_i  input  1  the decode stage holds its current instruction.
REQ-013 SHALL have port id_valid_o  output  1  id_pc_o, id_inst_o and id_jump_o carry a real instruction.
REQ-014 SHALL have port id_pc_o  output  ADDR_W  PC to decode.
REQ-015 SHALL have port id_inst_o  output  INST_W  instruction to decode.
REQ-016 SHALL have port id_jump_o  output  1  predicted-taken flag to decode.
REQ-017 SHALL have port count_o  output  $clog2(DEPTH)+1  number of entries in storage, excluding the output register.

Function
REQ-018 SHALL be organised as a DEPTH-entry circular FIFO (read pointer, write pointer, count) followed by one output register that drives all id_* outputs.
REQ-019 SHALL drive if_ready_o = (count_o < DEPTH); it depends only on registered count and does not depend on id_stall_i or on a pop in the same cycle.
REQ-020 SHALL define a push as (if_valid_i && if_ready_o && !flush_i).
REQ-021 SHALL, when id_stall_i=1 and flush_i=0, hold the output register unchanged and write any push into the FIFO at the write pointer.
REQ-022 SHALL, when id_stall_i=0 and flush_i=0 and count_o>0, load the FIFO head into the output register with id_valid_o=1, advance the read pointer, and write any push into the FIFO in the same cycle.
REQ-023 SHALL, when id_stall_i=0, flush_i=0, count_o=0 and a push occurs, bypass the incoming entry directly into the output register with id_valid_o=1, leaving the FIFO unchanged; fetch-to-decode latency is therefore 1 cycle.
REQ-024 SHALL, when id_stall_i=0, flush_i=0, count_o=0 and no push occurs, load a bubble into the output register: id_valid_o=0 and id_pc_o, id_inst_o, id_jump_o all 0.
REQ-025 SHALL update count as +1 on a FIFO write only, -1 on a FIFO read only, and unchanged when both occur together or when neither occurs.
REQ-026 SHALL wrap both pointers modulo DEPTH.
REQ-027 SHALL preserve strict program order: the output sequence equals the accepted-push sequence, with bubbles inserted only.
REQ-028 SHALL give flush_i priority over all other inputs: on the next edge, count=0, pointers=0, the output register is a bubble, and any same-cycle fetch input is discarded.
REQ-029 SHALL keep storage contents as don't-care after reset or flush; only pointers, count and the output register are cleared.
REQ-030 SHALL never overwrite an unread entry and never read an empty FIFO under any input combination.

Reset
REQ-031 SHALL, on any edge with rst=1, clear count_o, both pointers and the output register (id_valid_o=0, id_pc_o=0, id_inst_o=0, id_jump_o=0), which forces if_ready_o=1 on the following cycle.
REQ-032 SHALL apply reset mid-operation with the same priority as flush_i, discarding all in-flight entries.

Verification
REQ-033 SHALL pass this scenario: reset, then push PC 0x0,0x4,0x8 on consecutive cycles with id_stall_i=0 -> id outputs show 0x0,0x4,0x8 each one cycle after its push, and count_o stays 0 throughout.
REQ-034 SHALL pass this scenario: with DEPTH=4, hold id_stall_i=1 and push 5 times -> count_o reaches 4, if_ready_o=0, and the 5th instruction is not accepted; release the stall -> the 4 accepted entries drain in order, and if_ready_o returns to 1 after the first pop.
REQ-035 SHALL pass this scenario: at count_o=4, assert id_stall_i=0 with if_valid_i=1 -> no push occurs, and count_o becomes 3.
REQ-036 SHALL pass this scenario: at count_o=2, assert flush_i together with if_valid_i=1 -> on the next cycle count_o=0, id_valid_o=0, id_inst_o=0, and the flushed PCs never appear at the output.
REQ-037 SHALL pass this scenario: run a random push/stall pattern for more than 3*DEPTH entries -> pointer wrap-around preserves order, if_jump_i travels with its PC, and a scoreboard reports no mismatch.
REQ-038 SHALL pass this scenario: assert rst=1 while count_o=3 and id_valid_o=1 -> next cycle all outputs are 0 and if_ready_o=1.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry circular FIFO followed by
// a single output register that drives decode. When the FIFO is empty and
// decode is not stalled, an incoming fetch bypasses the FIFO straight into the
// output register, so the best-case fetch-to-decode latency is one cycle.
// Flush and reset share the highest priority and clear pointers, count and
// the output register; the storage array itself is never cleared.
module if_id_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     if_valid_i,
    input  logic [ADDR_W-1:0]        if_pc_i,
    input  logic [INST_W-1:0]        if_inst_i,
    input  logic                     if_jump_i,
    output logic                     if_ready_o,
    input  logic                     id_stall_i,
    output logic                     id_valid_o,
    output logic [ADDR_W-1:0]        id_pc_o,
    output logic [INST_W-1:0]        id_inst_o,
    output logic                     id_jump_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [INST_W-1:0] mem_inst [DEPTH];
    logic              mem_jump [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic push;
    logic fifo_empty;
    logic pop;
    logic bypass;
    logic fifo_wr;

    // Ready depends only on the registered count, so a full queue refuses
    // fetches even in a cycle where decode drains an entry.
    assign if_ready_o = (count < DEPTH_CNT);
    assign push       = if_valid_i && if_ready_o && !flush_i;
    assign fifo_empty = (count == '0);
    assign pop        = !id_stall_i && !fifo_empty && !flush_i;
    assign bypass     = !id_stall_i && fifo_empty && push;
    assign fifo_wr    = push && !bypass;
    assign count_o    = count;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({fifo_wr, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_pc[wr_ptr]   <= if_pc_i;
            mem_inst[wr_ptr] <= if_inst_i;
            mem_jump[wr_ptr] <= if_jump_i;
        end
    end

    // Output register: FIFO head first, else bypass, else a zeroed bubble.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            id_valid_o <= 1'b0;
            id_pc_o    <= '0;
            id_inst_o  <= '0;
            id_jump_o  <= 1'b0;
        end else if (!id_stall_i) begin
            if (!fifo_empty) begin
                id_valid_o <= 1'b1;
                id_pc_o    <= mem_pc[rd_ptr];
                id_inst_o  <= mem_inst[rd_ptr];
                id_jump_o  <= mem_jump[rd_ptr];
            end else if (push) begin
                id_valid_o <= 1'b1;
                id_pc_o    <= if_pc_i;
                id_inst_o  <= if_inst_i;
                id_jump_o  <= if_jump_i;
            end else begin
                id_valid_o <= 1'b0;
                id_pc_o    <= '0;
                id_inst_o  <= '0;
                id_jump_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: accepted fetches go into an expected queue, and a
// negedge monitor pops and compares each instruction that decode consumes.
// An occupancy/valid model tracks count_o, if_ready_o and id_valid_o.
module tb_if_id_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_i;
    logic              if_valid_i;
    logic [ADDR_W-1:0] if_pc_i;
    logic [INST_W-1:0] if_inst_i;
    logic              if_jump_i;
    logic              if_ready_o;
    logic              id_stall_i;
    logic              id_valid_o;
    logic [ADDR_W-1:0] id_pc_o;
    logic [INST_W-1:0] id_inst_o;
    logic              id_jump_o;
    logic [CNT_W-1:0]  count_o;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              jump;
    } ent_t;

    ent_t exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [CNT_W-1:0] m_cnt = '0;
    logic             m_vld = 1'b0;
    logic             m_acc;

    if_id_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .if_valid_i (if_valid_i),
        .if_pc_i    (if_pc_i),
        .if_inst_i  (if_inst_i),
        .if_jump_i  (if_jump_i),
        .if_ready_o (if_ready_o),
        .id_stall_i (id_stall_i),
        .id_valid_o (id_valid_o),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_jump_o  (id_jump_o),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [INST_W-1:0] inst_of(input logic [ADDR_W-1:0] pc);
        return {pc[15:0] ^ 16'h5A5A, pc[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [ADDR_W-1:0] pc, input logic j,
                        input logic st, input logic fl, input logic r);
        if_valid_i = v;
        if_pc_i    = pc;
        if_inst_i  = inst_of(pc);
        if_jump_i  = j;
        id_stall_i = st;
        flush_i    = fl;
        rst        = r;
        @(posedge clk);
        #1;
    endtask

    // A fetch is accepted when valid, the model has room, and no flush/reset.
    assign m_acc = if_valid_i && (m_cnt < DEPTH_CNT) && !flush_i && !rst;

    // Reference model: expected-queue fill plus occupancy and output-valid.
    always @(posedge clk) begin
        if (rst || flush_i) begin
            m_cnt <= '0;
            m_vld <= 1'b0;
            exp_q.delete();
        end else begin
            if (m_acc) begin
                exp_q.push_back('{pc: if_pc_i, inst: if_inst_i, jump: if_jump_i});
            end
            if (!id_stall_i) begin
                if (m_cnt != '0) begin
                    m_vld <= 1'b1;
                    if (!m_acc) m_cnt <= m_cnt - 1'b1;
                end else begin
                    m_vld <= m_acc;
                end
            end else if (m_acc) begin
                m_cnt <= m_cnt + 1'b1;
            end
        end
    end

    // Monitor: status checks every cycle, data check on every consumed output.
    always @(negedge clk) begin
        ent_t e;
        chk("count", count_o, m_cnt);
        chk("ready", if_ready_o, m_cnt < DEPTH_CNT);
        chk("valid", id_valid_o, m_vld);
        if (!id_valid_o) begin
            chk("bubble_pc", id_pc_o, 0);
            chk("bubble_inst", id_inst_o, 0);
            chk("bubble_jump", id_jump_o, 0);
        end else if (!id_stall_i && !flush_i && !rst) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got pc %0h expected no instruction at %0t", id_pc_o, $time);
            end else begin
                e = exp_q.pop_front();
                chk("out_pc", id_pc_o, e.pc);
                chk("out_inst", id_inst_o, e.inst);
                chk("out_jump", id_jump_o, e.jump);
            end
        end
    end

    initial begin
        logic [ADDR_W-1:0] pc;
        logic v, st, j;

        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("rst_valid", id_valid_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_ready", if_ready_o, 1);

        // Back-to-back fetches with no stall: one-cycle bypass, count stays 0.
        step(1, 32'h0, 0, 0, 0, 0);
        chk("byp_pc0", id_pc_o, 32'h0);
        chk("byp_vld0", id_valid_o, 1);
        step(1, 32'h4, 1, 0, 0, 0);
        chk("byp_pc4", id_pc_o, 32'h4);
        chk("byp_jmp4", id_jump_o, 1);
        step(1, 32'h8, 0, 0, 0, 0);
        chk("byp_pc8", id_pc_o, 32'h8);
        chk("byp_cnt", count_o, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("byp_bubble", id_valid_o, 0);

        // Fill under stall; the fifth fetch is refused.
        for (int i = 0; i < 5; i++) begin
            step(1, 32'h100 + 32'(4 * i), 1'(i), 1, 0, 0);
        end
        chk("full_cnt", count_o, 4);
        chk("full_ready", if_ready_o, 0);
        chk("full_hold", id_valid_o, 0);
        // Unstall with a fetch pending while full: no push, count drops to 3.
        step(1, 32'h200, 1, 0, 0, 0);
        chk("drain_pc0", id_pc_o, 32'h100);
        chk("drain_cnt", count_o, 3);
        chk("drain_ready", if_ready_o, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("drain_pc1", id_pc_o, 32'h104);
        step(0, 0, 0, 0, 0, 0);
        chk("drain_pc2", id_pc_o, 32'h108);
        step(0, 0, 0, 0, 0, 0);
        chk("drain_pc3", id_pc_o, 32'h10C);
        chk("drain_jmp3", id_jump_o, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("drain_empty", id_valid_o, 0);

        // Flush with two entries buffered and a fetch presented.
        step(1, 32'h2F0, 0, 0, 0, 0);
        step(1, 32'h300, 0, 1, 0, 0);
        step(1, 32'h304, 1, 1, 0, 0);
        chk("pre_flush_cnt", count_o, 2);
        step(1, 32'h308, 1, 1, 1, 0);
        chk("flush_cnt", count_o, 0);
        chk("flush_vld", id_valid_o, 0);
        chk("flush_inst", id_inst_o, 0);
        chk("flush_pc", id_pc_o, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        // Random push/stall mix across several pointer wraps.
        pc = 32'h1000;
        for (int i = 0; i < 60; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 2) == 0);
            j  = 1'($urandom_range(0, 1));
            step(v, pc, j, st, 0, 0);
            pc = pc + 32'h4;
        end
        for (int i = 0; i < DEPTH + 4; i++) step(0, 0, 0, 0, 0, 0);
        chk("rand_drained", exp_q.size(), 0);

        // Reset mid-operation with count 3 and a valid output.
        step(1, 32'h400, 0, 0, 0, 0);
        step(1, 32'h404, 1, 1, 0, 0);
        step(1, 32'h408, 0, 1, 0, 0);
        step(1, 32'h40C, 1, 1, 0, 0);
        chk("pre_rst_cnt", count_o, 3);
        chk("pre_rst_vld", id_valid_o, 1);
        step(1, 32'h410, 1, 0, 0, 1);
        chk("mid_rst_vld", id_valid_o, 0);
        chk("mid_rst_pc", id_pc_o, 0);
        chk("mid_rst_inst", id_inst_o, 0);
        chk("mid_rst_jump", id_jump_o, 0);
        chk("mid_rst_cnt", count_o, 0);
        chk("mid_rst_ready", if_ready_o, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        chk("final_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
